// File: rtl/avg_burst_feeder_if.sv
// Sample stream into the burst feeder and burst stream out to the averager.
// The feeder takes the slave side; the producer/averager pair takes the master side.
interface avg_burst_feeder_if #(
    parameter int BW = 4
);
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          m_val;
    logic [BW-1:0] m_data;
    logic          avg_done;

    modport slave (
        input  s_valid,
        input  s_data,
        input  avg_done,
        output s_ready,
        output m_val,
        output m_data
    );

    modport master (
        output s_valid,
        output s_data,
        output avg_done,
        input  s_ready,
        input  m_val,
        input  m_data
    );
endinterface

// File: rtl/avg_burst_feeder.sv
// Buffers samples and releases them as N-sample back-to-back bursts to the averager.
// Define AVG_BURST_FEEDER_STATS_EN to add the burst_cnt/stall_cnt counters.
module avg_burst_feeder #(
    parameter int N     = 4,
    parameter int BW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    avg_burst_feeder_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
`ifdef AVG_BURST_FEEDER_STATS_EN
    ,
    output logic [15:0]              burst_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WAIT
    } state_t;

    logic [LW-1:0] wr_q, wr_d;
    logic [LW-1:0] rd_q, rd_d;
    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] head;
    logic          s_ready;
    logic          push;
    logic          pop;
    logic          start;
    logic          more;

    state_t        state_q;
    logic [CW-1:0] beat_q;
    logic          m_val_q;
    logic [BW-1:0] m_data_q;

    // The first pop happens on the IDLE->BURST edge so no bubble precedes a burst.
    always_comb begin
        level   = wr_q - rd_q;
        s_ready = level < LW'(DEPTH);
        push    = bus.s_valid && s_ready;
        start   = (state_q == IDLE) && (level >= LW'(N));
        more    = (state_q == BURST) && (beat_q != CW'(N));
        pop     = start || more;
        head    = mem_q[rd_q[AW-1:0]];
        wr_d    = wr_q + LW'(push);
        rd_d    = rd_q + LW'(pop);
        busy    = state_q != IDLE;
    end

    assign bus.s_ready = s_ready;
    assign bus.m_val   = m_val_q;
    assign bus.m_data  = m_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            m_val_q  <= 1'b0;
            m_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= BURST;
                        beat_q   <= CW'(1);
                        m_val_q  <= 1'b1;
                        m_data_q <= head;
                    end
                end
                BURST: begin
                    if (more) begin
                        beat_q   <= beat_q + CW'(1);
                        m_data_q <= head;
                    end else begin
                        state_q <= WAIT;
                        beat_q  <= '0;
                        m_val_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.avg_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_val_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef AVG_BURST_FEEDER_STATS_EN
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        burst_end;
    logic        stall;

    always_comb begin
        burst_end   = (state_q == BURST) && !more;
        stall       = bus.s_valid && !s_ready;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (burst_end && (burst_cnt_q != 16'hFFFF)) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_avg_burst_feeder.sv
// Self-checking bench for avg_burst_feeder: vector table, scoreboard on the
// burst output, and hand sequences for hold-off, full FIFO and mid-burst reset.
module tb_avg_burst_feeder;

    localparam int N     = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [LW-1:0] level;
    logic          busy;
`ifdef AVG_BURST_FEEDER_STATS_EN
    logic [15:0]   burst_cnt;
    logic [15:0]   stall_cnt;
`endif

    avg_burst_feeder_if #(.BW(BW)) bus ();

    avg_burst_feeder #(
        .N(N),
        .BW(BW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus),
        .level(level),
        .busy(busy)
`ifdef AVG_BURST_FEEDER_STATS_EN
        ,
        .burst_cnt(burst_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [BW-1:0] d;
        logic          done;
        logic          mv;
        logic [BW-1:0] md;
        int            lv;
        logic          by;
    } vec_t;

    vec_t          tbl [11];
    logic [BW-1:0] sb [$];
    int            total  = 0;
    int            bad    = 0;
    int            mlev   = 0;
    int            run    = 0;
    int            nburst = 0;
    int            nstall = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive, step the level model, score any burst beat.
    task automatic cyc(input logic v, input logic [BW-1:0] d,
                       input logic done);
        logic          acc;
        logic [BW-1:0] e;
        bus.s_valid  = v;
        bus.s_data   = d;
        bus.avg_done = done;
        acc = v && (mlev < DEPTH);
        chk("s_ready", 32'(bus.s_ready), 32'(mlev < DEPTH));
        if (v && !acc) nstall++;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
        mlev += int'(acc);
        if (bus.m_val) mlev--;
        chk("level", 32'(level), 32'(mlev));
        if (bus.m_val) begin
            run++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(e));
            end
        end else if (run != 0) begin
            chk("burst_len", 32'(run), 32'(N));
            if (run == N) nburst++;
            run = 0;
        end
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.avg_done = 1'b0;
        #1;
        chk("rst_m_val", 32'(bus.m_val), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sb.delete();
        mlev   = 0;
        run    = 0;
        nburst = 0;
        nstall = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1, 1'b0};
        tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 2, 1'b0};
        tbl[2]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 3, 1'b0};
        tbl[3]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 3, 1'b1};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 2, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1, 1'b1};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 0, 1'b1};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 0, 1'b1};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 0, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 0, 1'b0};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].done);
            chk($sformatf("t%0d_m_val", i), 32'(bus.m_val), 32'(tbl[i].mv));
            chk($sformatf("t%0d_m_data", i), 32'(bus.m_data), 32'(tbl[i].md));
            chk($sformatf("t%0d_level", i), 32'(level), 32'(tbl[i].lv));
            chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].by));
        end

        // Three samples never start a burst; the fourth does.
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b1, 4'd6, 1'b0);
        cyc(1'b1, 4'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            chk("s2_hold_m_val", 32'(bus.m_val), 32'd0);
            chk("s2_hold_busy", 32'(busy), 32'd0);
        end
        cyc(1'b1, 4'd8, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        chk("s2_start", 32'(bus.m_val), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0);
        chk("s2_wait_busy", 32'(busy), 32'd1);
        chk("s2_wait_m_val", 32'(bus.m_val), 32'd0);
        cyc(1'b0, 4'd0, 1'b1);
        chk("s2_idle", 32'(busy), 32'd0);

        // Fill past a burst, reach full, stall, then gated bursts.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 1), 1'b0);
        chk("s3_after_burst_level", 32'(level), 32'd4);
        chk("s3_after_burst_ready", 32'(bus.s_ready), 32'd1);
        for (int i = 8; i < 12; i++) cyc(1'b1, 4'(i + 1), 1'b0);
        chk("s3_full_level", 32'(level), 32'd8);
        chk("s3_full_ready", 32'(bus.s_ready), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd15, 1'b0);
        chk("s3_full_hold", 32'(level), 32'd8);
`ifdef AVG_BURST_FEEDER_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(nstall));
        chk("burst_cnt_1", 32'(burst_cnt), 32'(nburst));
`endif
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'd0, 1'b0);
        chk("s3_held_m_val", 32'(bus.m_val), 32'd0);
        chk("s3_held_busy", 32'(busy), 32'd1);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0);
        chk("s3_b2_start", 32'(bus.m_val), 32'd1);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            chk("s3_done_ignored", 32'(busy), 32'd1);
            chk("s3_wait_m_val", 32'(bus.m_val), 32'd0);
        end
        cyc(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'd0, 1'b0);
        chk("s3_drained", 32'(level), 32'd0);
        chk("s3_bursts", 32'(nburst), 32'd3);
`ifdef AVG_BURST_FEEDER_STATS_EN
        chk("burst_cnt_3", 32'(burst_cnt), 32'(nburst));
`endif
        cyc(1'b0, 4'd0, 1'b1);

        // Reset in the second beat of a burst.
        do_reset();
        cyc(1'b1, 4'd3, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b1, 4'd7, 1'b0);
        cyc(1'b1, 4'd9, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        chk("s4_mid_burst", 32'(bus.m_val), 32'd1);
        do_reset();
        cyc(1'b1, 4'd10, 1'b0);
        cyc(1'b1, 4'd11, 1'b0);
        cyc(1'b1, 4'd12, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            chk("s4_no_stale", 32'(bus.m_val), 32'd0);
        end
        cyc(1'b1, 4'd13, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'd0, 1'b0);
        chk("s4_bursts", 32'(nburst), 32'd1);
        chk("s4_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_burst_feeder.md
Name: avg_burst_feeder

Overview:
- Upstream stage of the N-sample averager.
- Accepts samples over a valid/ready interface and buffers them in an internal FIFO.
- Releases exactly N samples to the averager as one contiguous burst of back-to-back valid cycles, because the averager has no backpressure.
- Holds off the next burst until the averager signals its result; the averager therefore never sees a partial or interleaved window.

Parameters:
N, 4, burst length = averager window; power of 2, >= 2
BW, 4, sample width in bits
DEPTH, 8, FIFO depth in samples; power of 2, >= N

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
s_valid  in  1  upstream sample valid
s_ready  out  1  feeder can accept a sample
s_data  in  BW  upstream sample
m_val  out  1  to averager inval; high for exactly N consecutive cycles per burst
m_data  out  BW  to averager in1; valid while m_val=1
avg_done  in  1  from averager outval; result produced
level  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  state != IDLE

Behaviour:
- Reset values (async, rstn low): FIFO empty, rd/wr pointers 0, level=0, state=IDLE, m_val=0, m_data=0, busy=0. s_ready=1 once rstn is released.
- Reset mid-burst: burst aborted immediately, m_val drops asynchronously, buffered samples discarded.
- FIFO: DEPTH entries; wr/rd pointers with one extra wrap bit; level = wr - rd.
- s_ready = (level < DEPTH), combinational from registered level only.
  - No pass-through when full: a pop in the same cycle does not raise s_ready.
- Push occurs when s_valid && s_ready; s_data is captured at that edge.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH and never underflows.
- FSM:
  - IDLE: if level >= N -> BURST, burst_cnt=0.
  - BURST: each cycle pop the head, m_val<=1, m_data<=head; burst_cnt++. After N pops -> WAIT.
  - WAIT: m_val<=0. When avg_done=1 -> IDLE.
- m_val and m_data are registered. m_data holds its last value when m_val=0.
- avg_done in IDLE or BURST: ignored. It is not latched.
- Level changes do not affect a burst in progress: BURST always issues exactly N samples, since entry requires level >= N.
- Latency:
  - N-th sample accepted at edge t -> level=N after t.
  - FSM leaves IDLE at edge t+1 -> m_val=1 on cycles following edges t+1 .. t+N.
  - m_val=0 after edge t+N+1.
- Back-to-back bursts:
  - Next burst starts no earlier than the edge after avg_done is sampled in WAIT, and only if level >= N at that point.
  - Otherwise the FSM waits in IDLE.
- Upstream may keep pushing during BURST and WAIT while s_ready=1.
- Sample order is preserved end to end (FIFO order).

Optional Feature:
- Macro: AVG_BURST_FEEDER_STATS_EN.
- Defined:
  - Adds output burst_cnt [15:0]: increments on every BURST->WAIT transition, saturates at 16'hFFFF.
  - Adds output stall_cnt [15:0]: increments each cycle s_valid && !s_ready, saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: both ports and their counters are absent; all other behaviour identical.

Test Plan:
- Reset, push 1,2,3,4 on consecutive cycles (N=4) -> m_val high 4 consecutive cycles with m_data 1,2,3,4 starting the cycle after the 4th push; busy=1; level returns to 0.
- Push only 3 samples -> m_val stays 0 indefinitely, level=3, state IDLE. A 4th push triggers the burst.
- Fill 8 samples with no avg_done -> first burst of 4 issued; after the burst, level=4 and s_ready=1. Push 4 more -> level=8, s_ready=0. Second burst held until avg_done pulses, then issues samples 5..8 in order.
- avg_done asserted during BURST -> ignored; FSM still enters WAIT and needs a fresh avg_done to return to IDLE.
- Full FIFO, s_valid held high for 3 cycles with STATS enabled -> no write accepted, stall_cnt=3; after a completed burst, burst_cnt=1.
- Assert rstn low in the 2nd burst cycle -> m_val=0 and level=0 immediately. After release, the first burst occurs only after 4 new pushes.
